// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready register slice: a main register feeds the consumer and a
// skid register absorbs one word on stall. Every output is driven straight from a flop.
module pipe_skid_stage #(
  parameter int unsigned         data_wid = 32,
  parameter logic [data_wid-1:0] rst_val  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [data_wid-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [data_wid-1:0] out_data,
  input  logic                out_ready,
  input  logic                flush,
  output logic [1:0]          occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [data_wid-1:0] main_q, main_d;
  logic [data_wid-1:0] skid_q, skid_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [1:0]          occ_q, occ_d;
  logic                in_fire;
  logic                out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops any same-cycle input word; the data registers simply keep their contents.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  // Status outputs are decoded from the next state so they come out of flops.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    occ_d       = 2'd0;
    case (state_d)
      ST_BUSY: begin
        out_valid_d = 1'b1;
        occ_d       = 2'd1;
      end
      ST_FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        occ_d       = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= rst_val;
      skid_q      <= rst_val;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and random-backpressure bench for pipe_skid_stage with an in-order
// scoreboard fed on every input fire and drained on every output fire.
module tb_pipe_skid_stage;

  localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        flush;
  logic [1:0]  occupancy;

  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic        hold_v;
  logic [31:0] hold_d;

  pipe_skid_stage #(.data_wid(32), .rst_val(RST_VAL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stable_data", out_data, hold_d);
        chk("stable_valid", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", {31'd0, out_valid}, 32'd0);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(in_data);
      hold_v = out_valid && !out_ready && !flush;
      hold_d = out_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the edge where the word fired.
  task automatic send(input logic [31:0] w);
    logic fired;
    in_valid = 1'b1;
    in_data  = w;
    fired    = 1'b0;
    for (int i = 0; i < 200 && !fired; i++) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
    end
    if (!fired) chk("send_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_sb_empty", exp_q.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic chk_state(input string tag, input logic [1:0] occ, input logic ov, input logic ir);
    chk({tag, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
    chk({tag, "_ovld"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, "_irdy"}, {31'd0, in_ready}, {31'd0, ir});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    hold_v    = 1'b0;
    hold_d    = '0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    #1 rst_n  = 1'b0;

    // Reset held for three cycles, then a back-to-back stream.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_data", out_data, RST_VAL);
      chk_state("rst", 2'd0, 1'b0, 1'b1);
    end
    rst_n = 1'b1;
    send(32'h11);
    chk("strm_11", out_data, 32'h11);
    chk_state("strm_a", 2'd1, 1'b1, 1'b1);
    send(32'h22);
    chk("strm_22", out_data, 32'h22);
    chk_state("strm_b", 2'd1, 1'b1, 1'b1);
    send(32'h33);
    chk("strm_33", out_data, 32'h33);
    chk_state("strm_c", 2'd1, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_state("strm_end", 2'd0, 1'b0, 1'b1);

    // Stall absorb: third word must wait upstream.
    out_ready = 1'b0;
    send(32'hA0);
    chk_state("stall1", 2'd1, 1'b1, 1'b1);
    send(32'hA1);
    chk_state("stall2", 2'd2, 1'b1, 1'b0);
    chk("stall_head", out_data, 32'hA0);
    in_valid = 1'b1;
    in_data  = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_state("stall_hold", 2'd2, 1'b1, 1'b0);
      chk("stall_hold_data", out_data, 32'hA0);
    end
    out_ready = 1'b1;
    send(32'hA2);
    in_valid = 1'b0;
    chk("stall_last", out_data, 32'hA2);
    chk_state("stall_last", 2'd1, 1'b1, 1'b1);
    drain();

    // Random backpressure: 1000 incrementing words.
    begin
      logic        offering;
      logic        fire;
      logic [31:0] nxt;
      int          sent;
      offering = 1'b0;
      nxt      = 32'h1000;
      sent     = 0;
      for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (!offering && $urandom_range(0, 1) == 1) begin
          offering = 1'b1;
          in_data  = nxt;
        end
        in_valid = offering;
        @(negedge clk);
        fire = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (fire) begin
          offering = 1'b0;
          nxt++;
          sent++;
        end
      end
      in_valid = 1'b0;
      chk("rand_sent", sent, 32'd1000);
      drain();
    end

    // Flush while FULL with a word offered in the same cycle.
    out_ready = 1'b0;
    send(32'hB0);
    send(32'hB1);
    chk_state("fl_full", 2'd2, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hB2;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_state("fl_after", 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_state("fl_idle", 2'd0, 1'b0, 1'b1);
    out_ready = 1'b1;
    send(32'hB3);
    in_valid = 1'b0;
    chk("fl_next", out_data, 32'hB3);
    drain();

    // Asynchronous reset pulse between edges while FULL.
    out_ready = 1'b0;
    send(32'hC0);
    send(32'hC1);
    chk_state("ar_full", 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_data", out_data, RST_VAL);
    chk_state("ar_now", 2'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(32'hD0);
    chk("ar_resume0", out_data, 32'hD0);
    send(32'hD1);
    chk("ar_resume1", out_data, 32'hD1);
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
